// File: rtl/chan_sweep_pkg.sv
// Shared types and default parameters for the channel SNR sweep controller.
package chan_sweep_pkg;

    localparam int unsigned DEF_OVERCLOCK   = 5;
    localparam int unsigned DEF_SNR_W       = 8;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_SETTLE_SYMS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT,
        ST_NEXT,
        ST_DONE
    } sweep_state_e;

    // Result record at the default widths
    typedef struct packed {
        logic signed [DEF_SNR_W-1:0] snr;
        logic [DEF_CNT_W-1:0]        errs;
        logic [DEF_CNT_W-1:0]        syms;
    } sweep_res_t;

endpackage

// File: rtl/sym_strobe_gen.sv
// Symbol-rate strobe: phase counter 0..OVERCLOCK-1, strobe registered on the last phase.
// clr_i/en_i qualify the upcoming cycle (first cycle of a run phase / cycle in a run phase).
module sym_strobe_gen
    import chan_sweep_pkg::*;
#(
    parameter int unsigned OVERCLOCK = DEF_OVERCLOCK
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic strobe_o
);

    localparam int unsigned PH_W = (OVERCLOCK > 1) ? $clog2(OVERCLOCK) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERCLOCK - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            strobe_q, strobe_d;

    always_comb begin
        phase_d  = phase_q;
        strobe_d = 1'b0;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
        strobe_d = en_i && (phase_d == PH_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/chan_snr_sweep_ctrl.sv
// Stepped SNR sweep scheduler: settle, measure symbol errors, report one record per point.
// Optional early stop on error count: define CHAN_SWEEP_EARLY_STOP_EN.
module chan_snr_sweep_ctrl
    import chan_sweep_pkg::*;
#(
    parameter int unsigned OVERCLOCK   = DEF_OVERCLOCK,
    parameter int unsigned SNR_W       = DEF_SNR_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SETTLE_SYMS = DEF_SETTLE_SYMS
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic signed [SNR_W-1:0] snr_start_i,
    input  logic signed [SNR_W-1:0] snr_stop_i,
    input  logic [SNR_W-1:0]        snr_step_i,
    input  logic [CNT_W-1:0]        syms_per_point_i,
`ifdef CHAN_SWEEP_EARLY_STOP_EN
    input  logic [CNT_W-1:0]        max_errs_i,
`endif
    input  logic                    sym_err_i,
    output logic                    sym_en_o,
    output logic signed [SNR_W-1:0] snr_out_o,
    output logic                    busy_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic signed [SNR_W-1:0] res_snr_o,
    output logic [CNT_W-1:0]        res_errs_o,
    output logic [CNT_W-1:0]        res_syms_o,
    output logic                    done_o
);

    localparam int unsigned SETTLE_LAST = (SETTLE_SYMS > 0) ? SETTLE_SYMS - 1 : 0;
    localparam sweep_state_e RUN_ST     = (SETTLE_SYMS == 0) ? ST_MEASURE : ST_SETTLE;

    sweep_state_e state_q, state_d;

    logic signed [SNR_W-1:0] snr_q, snr_d, stop_q, stop_d, res_snr_q, res_snr_d;
    logic [SNR_W-1:0]        step_q, step_d;
    logic [CNT_W-1:0]        spp_q, spp_d, settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d, err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]        res_errs_q, res_errs_d, res_syms_q, res_syms_d;
    logic                    busy_q, busy_d, done_q, done_d, res_valid_q, res_valid_d;
`ifdef CHAN_SWEEP_EARLY_STOP_EN
    logic [CNT_W-1:0]        max_errs_q, max_errs_d;
`endif

    logic                    strobe;
    logic                    strobe_en_c, strobe_clr_c;
    logic                    meas_last_c;
    logic signed [SNR_W:0]   snr_sum_c, stop_ext_c;
    logic [CNT_W-1:0]        sym_cnt_inc_c, err_cnt_inc_c;

    sym_strobe_gen #(
        .OVERCLOCK (OVERCLOCK)
    ) u_strobe (
        .clk_i    (clk_i),
        .rst_ni   (reset_ni),
        .clr_i    (strobe_clr_c),
        .en_i     (strobe_en_c),
        .strobe_o (strobe)
    );

    always_comb begin
        state_d      = state_q;
        snr_d        = snr_q;
        stop_d       = stop_q;
        step_d       = step_q;
        spp_d        = spp_q;
        settle_cnt_d = settle_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        err_cnt_d    = err_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        res_valid_d  = res_valid_q;
        res_snr_d    = res_snr_q;
        res_errs_d   = res_errs_q;
        res_syms_d   = res_syms_q;
`ifdef CHAN_SWEEP_EARLY_STOP_EN
        max_errs_d   = max_errs_q;
`endif
        // Widened so the step never wraps past the positive limit
        snr_sum_c     = {snr_q[SNR_W-1], snr_q} + {1'b0, step_q};
        stop_ext_c    = {stop_q[SNR_W-1], stop_q};
        sym_cnt_inc_c = sym_cnt_q + CNT_W'(1);
        err_cnt_inc_c = (sym_err_i && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        meas_last_c   = (sym_cnt_inc_c == spp_q);
`ifdef CHAN_SWEEP_EARLY_STOP_EN
        if ((max_errs_q != '0) && (err_cnt_inc_c >= max_errs_q)) begin
            meas_last_c = 1'b1;
        end
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    snr_d        = snr_start_i;
                    stop_d       = snr_stop_i;
                    step_d       = (snr_step_i == '0) ? SNR_W'(1) : snr_step_i;
                    spp_d        = (syms_per_point_i == '0) ? CNT_W'(1) : syms_per_point_i;
`ifdef CHAN_SWEEP_EARLY_STOP_EN
                    max_errs_d   = max_errs_i;
`endif
                    settle_cnt_d = '0;
                    sym_cnt_d    = '0;
                    err_cnt_d    = '0;
                    busy_d       = 1'b1;
                    state_d      = RUN_ST;
                end
            end
            ST_SETTLE: begin
                if (strobe) begin
                    if (settle_cnt_q == CNT_W'(SETTLE_LAST)) begin
                        settle_cnt_d = '0;
                        state_d      = ST_MEASURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MEASURE: begin
                if (strobe) begin
                    sym_cnt_d = sym_cnt_inc_c;
                    err_cnt_d = err_cnt_inc_c;
                    if (meas_last_c) begin
                        res_valid_d = 1'b1;
                        res_snr_d   = snr_q;
                        res_errs_d  = err_cnt_inc_c;
                        res_syms_d  = sym_cnt_inc_c;
                        state_d     = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (snr_sum_c > stop_ext_c) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    snr_d        = snr_sum_c[SNR_W-1:0];
                    settle_cnt_d = '0;
                    sym_cnt_d    = '0;
                    err_cnt_d    = '0;
                    state_d      = RUN_ST;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        strobe_en_c  = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
        strobe_clr_c = strobe_en_c && (state_d != state_q);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            snr_q        <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            spp_q        <= '0;
            settle_cnt_q <= '0;
            sym_cnt_q    <= '0;
            err_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_snr_q    <= '0;
            res_errs_q   <= '0;
            res_syms_q   <= '0;
`ifdef CHAN_SWEEP_EARLY_STOP_EN
            max_errs_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            snr_q        <= snr_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            spp_q        <= spp_d;
            settle_cnt_q <= settle_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_snr_q    <= res_snr_d;
            res_errs_q   <= res_errs_d;
            res_syms_q   <= res_syms_d;
`ifdef CHAN_SWEEP_EARLY_STOP_EN
            max_errs_q   <= max_errs_d;
`endif
        end
    end

    assign sym_en_o    = strobe;
    assign snr_out_o   = snr_q;
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign res_snr_o   = res_snr_q;
    assign res_errs_o  = res_errs_q;
    assign res_syms_o  = res_syms_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_chan_snr_sweep_ctrl.sv
// Directed self-checking bench for chan_snr_sweep_ctrl (OVERCLOCK=5, SETTLE_SYMS=2).
module tb_chan_snr_sweep_ctrl;

    localparam int unsigned OC  = 5;
    localparam int unsigned SW  = 8;
    localparam int unsigned CW  = 32;
    localparam int unsigned SET = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [SW-1:0] snr_start = '0;
    logic signed [SW-1:0] snr_stop = '0;
    logic [SW-1:0]        snr_step = '0;
    logic [CW-1:0]        spp = '0;
`ifdef CHAN_SWEEP_EARLY_STOP_EN
    logic [CW-1:0]        max_errs = '0;
`endif
    logic                 sym_err = 1'b0;
    logic                 res_ready = 1'b0;
    logic                 sym_en, busy, res_valid, done;
    logic signed [SW-1:0] snr_out, res_snr;
    logic [CW-1:0]        res_errs, res_syms;

    int tests_run = 0;
    int tests_failed = 0;

    // Per-sweep observations
    int                   rec_n, strobes, done_pulses, bad_gaps, first_lat;
    int                   strobe_while_valid, field_changes, timeout;
    logic                 busy_first;
    logic signed [SW-1:0] rec_snr [8];
    logic [CW-1:0]        rec_errs [8];
    logic [CW-1:0]        rec_syms [8];
    int                   valid_cycles [8];

    chan_snr_sweep_ctrl #(
        .OVERCLOCK   (OC),
        .SNR_W       (SW),
        .CNT_W       (CW),
        .SETTLE_SYMS (SET)
    ) dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .start_i          (start),
        .snr_start_i      (snr_start),
        .snr_stop_i       (snr_stop),
        .snr_step_i       (snr_step),
        .syms_per_point_i (spp),
`ifdef CHAN_SWEEP_EARLY_STOP_EN
        .max_errs_i       (max_errs),
`endif
        .sym_err_i        (sym_err),
        .sym_en_o         (sym_en),
        .snr_out_o        (snr_out),
        .busy_o           (busy),
        .res_valid_o      (res_valid),
        .res_ready_i      (res_ready),
        .res_snr_o        (res_snr),
        .res_errs_o       (res_errs),
        .res_syms_o       (res_syms),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    // err_mode: 0 none, 1 every 2nd strobe (global count), 2 every strobe
    task automatic do_sweep(input logic signed [SW-1:0] s0, input logic signed [SW-1:0] s1,
                            input logic [SW-1:0] st, input logic [CW-1:0] n,
                            input int err_mode, input int stall, input bit inject);
        int  vcnt, last_strobe;
        bit  valid_since, done_seen, ok_exit;
        logic signed [SW-1:0] h_snr;
        logic [CW-1:0] h_errs, h_syms;
        rec_n = 0; strobes = 0; done_pulses = 0; bad_gaps = 0; first_lat = 0;
        strobe_while_valid = 0; field_changes = 0; timeout = 0;
        vcnt = 0; last_strobe = 0; valid_since = 0; done_seen = 0; ok_exit = 0;
        h_snr = '0; h_errs = '0; h_syms = '0;
        @(negedge clk);
        snr_start = s0; snr_stop = s1; snr_step = st; spp = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_first = busy;
        for (int c = 1; c <= 2000 && !ok_exit; c++) begin
            start = 1'b0;
            if (sym_en) begin
                strobes++;
                if (strobes == 1) first_lat = c;
                else if (!valid_since && (c - last_strobe) != OC) bad_gaps++;
                last_strobe = c;
                valid_since = 1'b0;
                sym_err = (err_mode == 2) || (err_mode == 1 && (strobes % 2) == 0);
                if (inject && strobes == 7) begin
                    start = 1'b1; snr_start = 8'sd50;
                end
            end else begin
                sym_err = 1'b0;
            end
            if (res_valid) begin
                valid_since = 1'b1;
                if (sym_en) strobe_while_valid++;
                if (vcnt > 0 && {h_snr, h_errs, h_syms} !== {res_snr, res_errs, res_syms})
                    field_changes++;
                h_snr = res_snr; h_errs = res_errs; h_syms = res_syms;
                vcnt++;
                if (vcnt > stall) begin
                    res_ready = 1'b1;
                    if (rec_n < 8) begin
                        rec_snr[rec_n] = res_snr; rec_errs[rec_n] = res_errs;
                        rec_syms[rec_n] = res_syms; valid_cycles[rec_n] = vcnt;
                    end
                    rec_n++;
                    vcnt = 0;
                end else begin
                    res_ready = 1'b0;
                end
            end else begin
                res_ready = 1'b0;
                vcnt = 0;
            end
            if (done) begin
                done_pulses++;
                done_seen = 1'b1;
            end
            if (done_seen && !busy) ok_exit = 1'b1;
            else @(negedge clk);
        end
        if (!ok_exit) timeout = 1;
        sym_err = 1'b0;
        res_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({sym_en, busy, res_valid, done, snr_out, res_snr, res_errs, res_syms} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got sym_en=%b busy=%b valid=%b done=%b snr=%0d, want all 0",
                     sym_en, busy, res_valid, done, snr_out);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({sym_en, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_quiet: got sym_en=%b busy=%b done=%b, want 000", sym_en, busy, done);
        end
    endtask

    task automatic test_basic_sweep();
        do_sweep(8'sd0, 8'sd4, 8'd2, 32'd3, 0, 0, 1'b1);
        tests_run++;
        if (timeout != 0) begin tests_failed++; $display("FAIL basic_timeout: sweep did not finish"); end
        tests_run++;
        if (rec_n != 3) begin tests_failed++; $display("FAIL basic_rec_count: got %0d want 3", rec_n); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rec_snr[i] !== SW'(2 * i) || rec_errs[i] !== 32'd0 || rec_syms[i] !== 32'd3) begin
                tests_failed++;
                $display("FAIL basic_rec%0d: got (%0d,%0d,%0d) want (%0d,0,3)",
                         i, rec_snr[i], rec_errs[i], rec_syms[i], 2 * i);
            end
        end
        tests_run++;
        if (first_lat != 5) begin tests_failed++; $display("FAIL first_strobe_lat: got %0d want 5", first_lat); end
        tests_run++;
        if (bad_gaps != 0) begin tests_failed++; $display("FAIL strobe_period: %0d gaps not 5", bad_gaps); end
        tests_run++;
        if (strobes != 15) begin tests_failed++; $display("FAIL strobe_count: got %0d want 15", strobes); end
        tests_run++;
        if (done_pulses != 1) begin tests_failed++; $display("FAIL done_pulses: got %0d want 1", done_pulses); end
        tests_run++;
        if (busy_first !== 1'b1) begin tests_failed++; $display("FAIL busy_after_start: got %b want 1", busy_first); end
        tests_run++;
        if (busy !== 1'b0 || snr_out !== 8'sd4) begin
            tests_failed++;
            $display("FAIL after_done: got busy=%b snr_out=%0d want 0/4", busy, snr_out);
        end
    endtask

    task automatic test_errors();
        do_sweep(8'sd0, 8'sd0, 8'd1, 32'd10, 1, 0, 1'b0);
        tests_run++;
        if (timeout != 0 || rec_n != 1 || rec_errs[0] !== 32'd5 || rec_syms[0] !== 32'd10) begin
            tests_failed++;
            $display("FAIL err_count: got n=%0d errs=%0d syms=%0d want 1/5/10",
                     rec_n, rec_errs[0], rec_syms[0]);
        end
        do_sweep(8'sd1, 8'sd1, 8'd1, 32'd3, 2, 0, 1'b0);
        tests_run++;
        if (rec_n != 1 || rec_errs[0] !== 32'd3 || rec_syms[0] !== 32'd3) begin
            tests_failed++;
            $display("FAIL all_errs: got n=%0d errs=%0d syms=%0d want 1/3/3", rec_n, rec_errs[0], rec_syms[0]);
        end
    endtask

    task automatic test_backpressure();
        do_sweep(8'sd3, 8'sd3, 8'd1, 32'd2, 0, 20, 1'b0);
        tests_run++;
        if (rec_n != 1 || valid_cycles[0] != 21) begin
            tests_failed++;
            $display("FAIL bp_hold: got n=%0d valid_cycles=%0d want 1/21", rec_n, valid_cycles[0]);
        end
        tests_run++;
        if (strobe_while_valid != 0 || field_changes != 0) begin
            tests_failed++;
            $display("FAIL bp_stall: got strobes=%0d changes=%0d want 0/0", strobe_while_valid, field_changes);
        end
        tests_run++;
        if (rec_snr[0] !== 8'sd3 || rec_errs[0] !== 32'd0 || rec_syms[0] !== 32'd2) begin
            tests_failed++;
            $display("FAIL bp_record: got (%0d,%0d,%0d) want (3,0,2)", rec_snr[0], rec_errs[0], rec_syms[0]);
        end
    endtask

    task automatic test_edges();
        do_sweep(8'sd10, -8'sd5, 8'd1, 32'd1, 0, 0, 1'b0);
        tests_run++;
        if (rec_n != 1 || rec_snr[0] !== 8'sd10) begin
            tests_failed++;
            $display("FAIL start_gt_stop: got n=%0d snr=%0d want 1/10", rec_n, rec_snr[0]);
        end
        do_sweep(8'sd120, 8'sd127, 8'd10, 32'd1, 0, 0, 1'b0);
        tests_run++;
        if (timeout != 0 || rec_n != 1 || rec_snr[0] !== 8'sd120) begin
            tests_failed++;
            $display("FAIL no_wrap: got n=%0d snr=%0d want 1/120", rec_n, rec_snr[0]);
        end
        do_sweep(-8'sd1, 8'sd0, 8'd0, 32'd0, 0, 0, 1'b0);
        tests_run++;
        if (rec_n != 2 || rec_snr[0] !== -8'sd1 || rec_snr[1] !== 8'sd0
            || rec_syms[0] !== 32'd1 || rec_syms[1] !== 32'd1) begin
            tests_failed++;
            $display("FAIL zero_step_spp: got n=%0d snr=%0d,%0d syms=%0d,%0d want 2 -1,0 1,1",
                     rec_n, rec_snr[0], rec_snr[1], rec_syms[0], rec_syms[1]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        snr_start = 8'sd9; snr_stop = 8'sd9; snr_step = 8'd1; spp = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && seen < 3; c++) begin
            if (sym_en) seen++;
            if (seen < 3) @(negedge clk);
        end
        tests_run++;
        if (seen != 3 || snr_out !== 8'sd9) begin
            tests_failed++;
            $display("FAIL mid_reach_measure: got strobes=%0d snr_out=%0d want 3/9", seen, snr_out);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sym_en, busy, res_valid, done, snr_out, res_snr, res_errs, res_syms} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%b snr_out=%0d res_snr=%0d, want all 0",
                     busy, snr_out, res_snr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_sweep(8'sd9, 8'sd9, 8'd1, 32'd3, 0, 0, 1'b0);
        tests_run++;
        if (timeout != 0 || rec_n != 1 || rec_snr[0] !== 8'sd9 || rec_syms[0] !== 32'd3 || first_lat != 5) begin
            tests_failed++;
            $display("FAIL restart: got n=%0d snr=%0d syms=%0d lat=%0d want 1/9/3/5",
                     rec_n, rec_snr[0], rec_syms[0], first_lat);
        end
    endtask

`ifdef CHAN_SWEEP_EARLY_STOP_EN
    task automatic test_early_stop();
        max_errs = 32'd4;
        do_sweep(8'sd0, 8'sd0, 8'd1, 32'd100, 2, 0, 1'b0);
        max_errs = 32'd0;
        tests_run++;
        if (rec_n != 1 || rec_errs[0] !== 32'd4 || rec_syms[0] !== 32'd4) begin
            tests_failed++;
            $display("FAIL early_stop: got n=%0d errs=%0d syms=%0d want 1/4/4", rec_n, rec_errs[0], rec_syms[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_sweep();
        test_errors();
        test_backpressure();
        test_edges();
        test_reset_mid();
`ifdef CHAN_SWEEP_EARLY_STOP_EN
        test_early_stop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/chan_snr_sweep_ctrl.md
Name: chan_snr_sweep_ctrl

Overview:
- Scheduler that drives the channel model's `clk_enable`/symbol strobe and its SNR input through a stepped sweep.
- At each SNR point it settles, then measures symbol errors, then reports one result record per point over a valid/ready handshake.
- Sits between the testbench/top-level control and the channel + QAM demod chain; sole owner of channel SNR and symbol timing.

Parameters:
- OVERCLOCK, 5, clk cycles per symbol strobe (>=1)
- SNR_W, 8, width of signed SNR in dB (integer dB)
- CNT_W, 32, width of symbol and error counters
- SETTLE_SYMS, 64, symbols discarded after each SNR change (>=0)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- snr_start  in  SNR_W signed  first SNR point
- snr_stop  in  SNR_W signed  last allowed SNR point (inclusive)
- snr_step  in  SNR_W unsigned  SNR increment; 0 treated as 1
- syms_per_point  in  CNT_W  measured symbols per point; 0 treated as 1
- sym_err  in  1  symbol error flag from checker, sampled only with sym_en
- sym_en  out  1  one-cycle symbol strobe (channel `clk_enable`)
- snr_out  out  SNR_W signed  current SNR to channel
- busy  out  1  high from accepted start until DONE exits
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_snr  out  SNR_W signed  SNR of record
- res_errs  out  CNT_W  errors counted at that point
- res_syms  out  CNT_W  symbols measured at that point
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset (async assert, sync deassert by the user): state IDLE; sym_en, busy, res_valid, done = 0; snr_out, res_snr, res_errs, res_syms, all counters = 0.
- Reset mid-sweep aborts immediately. No partial result is emitted.
- State IDLE:
  - start=1 latches snr_start, snr_stop, snr_step and syms_per_point; load snr_out=snr_start.
  - Go to SETTLE, or to MEASURE if SETTLE_SYMS=0. busy=1 from the next cycle.
- Strobe generator:
  - Phase counter 0..OVERCLOCK-1, cleared on entry to SETTLE and to MEASURE.
  - sym_en=1 when the counter equals OVERCLOCK-1, so the first strobe occurs OVERCLOCK cycles after entry.
  - With OVERCLOCK=1, sym_en is high every cycle in SETTLE/MEASURE.
  - sym_en=0 in all other states.
- SETTLE: count strobes; after the SETTLE_SYMS-th strobe, go to MEASURE. sym_err is ignored.
- MEASURE:
  - Each strobe increments sym_cnt.
  - If sym_err=1 on the same cycle, err_cnt increments, saturating at 2^CNT_W-1.
  - After the strobe on which sym_cnt reaches the latched syms_per_point, go to REPORT.
- REPORT:
  - res_valid=1, with res_snr=snr_out, res_errs=err_cnt, res_syms=sym_cnt.
  - Record fields stay stable while res_valid=1 and res_ready=0.
  - Transfer occurs on the cycle with res_valid&&res_ready; then go to NEXT. res_ready may be high on the first REPORT cycle (1-cycle transfer).
  - No strobes in REPORT: the channel is stalled under backpressure.
- NEXT (1 cycle):
  - Compute snr_out+step in SNR_W+1 bits, signed compare, no wrap.
  - If the sum > snr_stop, go to DONE.
  - Else snr_out updates, counters clear, go to SETTLE (or MEASURE).
- snr_start > snr_stop: exactly one point at snr_start is measured and reported.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE. snr_out holds its last value.
- start asserted in any state other than IDLE is ignored.

Optional Feature:
- Macro: CHAN_SWEEP_EARLY_STOP_EN.
- When defined:
  - Adds input `max_errs[CNT_W]`, latched at start.
  - In MEASURE, once err_cnt reaches max_errs (and max_errs != 0), go to REPORT after that strobe.
  - res_syms reports the symbols actually measured.
- When undefined: no port; every point measures exactly syms_per_point symbols.

Decomposition:
- Package `chan_sweep_pkg`:
  - State enum typedef (IDLE, SETTLE, MEASURE, REPORT, NEXT, DONE).
  - Result record struct (snr, errs, syms).
  - Default parameter constants.
- One sub-module `sym_strobe_gen`: phase counter with clear and enable, producing sym_en. It is reused for the other symbol-rate blocks.

Test Plan:
- OVERCLOCK=5, SETTLE_SYMS=2, start: snr 0..4 step 2, syms_per_point=3, res_ready=1, sym_err=0.
  - 3 records (0,0,3), (2,0,3), (4,0,3).
  - sym_en period exactly 5 cycles.
  - done pulse once.
- sym_err=1 on every 2nd strobe, syms_per_point=10 -> res_errs=5 (errors during SETTLE not counted).
- res_ready held 0 for 20 cycles in REPORT -> res_valid stays 1, fields stable, no sym_en; accepted on the cycle ready rises.
- Edge cases:
  - snr_start=10, snr_stop=-5 -> single record at 10.
  - snr_start=120, stop=127, step=10, SNR_W=8 -> single record, no wrap to negative.
- reset driven low mid-MEASURE -> all outputs 0 asynchronously; subsequent start restarts cleanly from snr_start.
- With CHAN_SWEEP_EARLY_STOP_EN, max_errs=4, sym_err=1 always, syms_per_point=100 -> record errs=4, syms=4.
